// File: rtl/pool_layer_ctrl.sv
// pool_layer_ctrl: sequences a 2x2/stride-2 max-pooling engine over a multi-channel feature map
module pool_layer_ctrl #(
    parameter int IMG_W   = 30,
    parameter int IMG_H   = 30,
    parameter int DATA_W  = 22,
    parameter int MAX_CH  = 8,
    parameter int TIMEOUT = 1024,
    localparam int NPIX   = IMG_W * IMG_H,
    localparam int NOUT   = NPIX / 4,
    localparam int SRC_AW = $clog2(MAX_CH * NPIX),
    localparam int DST_AW = $clog2(MAX_CH * NOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [3:0]        cmd_num_ch,
    output logic              cmd_busy,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              src_rd_req,
    output logic [SRC_AW-1:0] src_rd_addr,
    input  logic              src_rd_gnt,
    input  logic [DATA_W-1:0] src_rd_data,
    output logic              pool_start,
    output logic              pool_pixel_valid,
    output logic [DATA_W-1:0] pool_pixel_in,
    input  logic [DATA_W-1:0] pool_result_in,
    input  logic              pool_result_valid,
    input  logic              pool_done,
    output logic              dst_wr_en,
    output logic [DST_AW-1:0] dst_wr_addr,
    output logic [DATA_W-1:0] dst_wr_data
);
    localparam int PW = $clog2(NPIX + 1);
    localparam int KW = $clog2(NOUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START_CH, FEED, DRAIN, COLLECT, FINISH, ERROR} state_t;

    state_t            state;
    logic [3:0]        num_ch;
    logic [3:0]        ch;
    logic [PW-1:0]     issued;
    logic [KW-1:0]     k;
    logic [TW-1:0]     wd;
    logic [DST_AW-1:0] dst_addr;
    logic              rd_vld;
    logic              grant;
    logic              wr_hit;
    logic              done_ok;

    // Channels are contiguous in both buffers, so the source and destination
    // addresses simply keep counting across channel boundaries.
    assign grant            = src_rd_req & src_rd_gnt;
    assign wr_hit           = state == COLLECT && pool_result_valid && k < KW'(NOUT);
    assign done_ok          = k + KW'(wr_hit) == KW'(NOUT);
    assign pool_pixel_valid = rd_vld;
    assign pool_pixel_in    = rd_vld ? src_rd_data : '0;
    assign dst_wr_en        = wr_hit;
    assign dst_wr_addr      = dst_addr;
    assign dst_wr_data      = wr_hit ? pool_result_in : '0;

    // Read data returns one cycle after a granted request; mark it as a pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_vld <= 1'b0;
        else      rd_vld <= grant;
    end

    // Command sequencer: channel loop, pixel feed, result collection and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            num_ch      <= '0;
            ch          <= '0;
            issued      <= '0;
            k           <= '0;
            wd          <= '0;
            dst_addr    <= '0;
            src_rd_addr <= '0;
            src_rd_req  <= 1'b0;
            pool_start  <= 1'b0;
            cmd_busy    <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            pool_start <= 1'b0;
            cmd_done   <= 1'b0;
            if (grant) src_rd_addr <= src_rd_addr + SRC_AW'(1);
            if (wr_hit) begin
                k        <= k + KW'(1);
                dst_addr <= dst_addr + DST_AW'(1);
            end
            case (state)
                IDLE: if (cmd_start) begin
                    num_ch      <= cmd_num_ch;
                    ch          <= '0;
                    src_rd_addr <= '0;
                    dst_addr    <= '0;
                    cmd_err     <= 1'b0;
                    cmd_busy    <= 1'b1;
                    pool_start  <= cmd_num_ch != '0 && cmd_num_ch <= 4'(MAX_CH);
                    state       <= cmd_num_ch == '0 ? FINISH :
                                   cmd_num_ch > 4'(MAX_CH) ? ERROR : START_CH;
                end
                START_CH: begin
                    issued     <= '0;
                    k          <= '0;
                    src_rd_req <= 1'b1;
                    state      <= FEED;
                end
                FEED: if (grant) begin
                    issued <= issued + PW'(1);
                    if (issued == PW'(NPIX - 1)) begin
                        src_rd_req <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    wd    <= '0;
                    state <= COLLECT;
                end
                COLLECT: if (pool_done) begin
                    if (!done_ok) state <= ERROR;
                    else if (ch == num_ch - 4'd1) state <= FINISH;
                    else begin
                        ch         <= ch + 4'd1;
                        pool_start <= 1'b1;
                        state      <= START_CH;
                    end
                end else if (wd == TW'(TIMEOUT - 1)) state <= ERROR;
                else wd <= wd + TW'(1);
                FINISH: begin
                    cmd_done <= 1'b1;
                    cmd_busy <= 1'b0;
                    state    <= IDLE;
                end
                ERROR: begin
                    cmd_err  <= 1'b1;
                    cmd_done <= 1'b1;
                    cmd_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_layer_ctrl.sv
// tb_pool_layer_ctrl: scoreboard bench with source-memory, arbiter and pooling-engine models
module tb_pool_layer_ctrl;
    localparam int IMG_W   = 30;
    localparam int IMG_H   = 30;
    localparam int DATA_W  = 22;
    localparam int MAX_CH  = 8;
    localparam int TIMEOUT = 1024;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int NOUT    = NPIX / 4;
    localparam int SRC_AW  = $clog2(MAX_CH * NPIX);
    localparam int DST_AW  = $clog2(MAX_CH * NOUT);

    logic              clk;
    logic              rst;
    logic              cmd_start;
    logic [3:0]        cmd_num_ch;
    logic              cmd_busy;
    logic              cmd_done;
    logic              cmd_err;
    logic              src_rd_req;
    logic [SRC_AW-1:0] src_rd_addr;
    logic              src_rd_gnt;
    logic [DATA_W-1:0] src_rd_data;
    logic              pool_start;
    logic              pool_pixel_valid;
    logic [DATA_W-1:0] pool_pixel_in;
    logic [DATA_W-1:0] pool_result_in;
    logic              pool_result_valid;
    logic              pool_done;
    logic              dst_wr_en;
    logic [DST_AW-1:0] dst_wr_addr;
    logic [DATA_W-1:0] dst_wr_data;

    pool_layer_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .MAX_CH(MAX_CH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_num_ch(cmd_num_ch),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .src_rd_req(src_rd_req), .src_rd_addr(src_rd_addr),
        .src_rd_gnt(src_rd_gnt), .src_rd_data(src_rd_data),
        .pool_start(pool_start), .pool_pixel_valid(pool_pixel_valid), .pool_pixel_in(pool_pixel_in),
        .pool_result_in(pool_result_in), .pool_result_valid(pool_result_valid), .pool_done(pool_done),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic signed [DATA_W-1:0] mem [MAX_CH*NPIX];
    int exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    bit exp_err[$];
    int cyc = 0, starts = 0, dones = 0, pix = 0;
    int last_pix_cyc = 0, done_cyc = 0, first_pix_cyc = -1, start_cyc = 0;
    bit full_gnt = 1'b1, res_gaps = 1'b0, nodone = 1'b0;
    int extra = 0;

    task automatic check(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_max(input int c, input int k);
        logic signed [DATA_W-1:0] m;
        int base;
        base = c * NPIX + 2 * (k / (IMG_W / 2)) * IMG_W + 2 * (k % (IMG_W / 2));
        m = mem[base];
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
                if (mem[base + dy * IMG_W + dx] > m) m = mem[base + dy * IMG_W + dx];
        return m;
    endfunction

    // Memory behind the arbiter: random or solid grant, data one cycle after req&gnt
    initial begin
        bit g, iss;
        int a;
        src_rd_gnt = 1'b0;
        src_rd_data = '0;
        forever begin
            @(negedge clk);
            g = full_gnt ? 1'b1 : 1'($urandom_range(0, 1));
            src_rd_gnt = g;
            iss = src_rd_req && g;
            a = int'(src_rd_addr);
            @(posedge clk);
            #1;
            src_rd_data = iss ? mem[a] : DATA_W'($urandom);
        end
    end

    // Pooling engine: buffers a channel, then emits maxima (+surplus) and done
    initial begin
        logic signed [DATA_W-1:0] px[$];
        logic [DATA_W-1:0] rq[$];
        logic signed [DATA_W-1:0] m, v;
        bit emitting;
        int delay, base;
        emitting = 1'b0;
        delay = 0;
        pool_result_valid = 1'b0;
        pool_result_in = '0;
        pool_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                px.delete();
                rq.delete();
                emitting = 1'b0;
            end else begin
                if (pool_start) begin
                    px.delete();
                    rq.delete();
                    emitting = 1'b0;
                end
                if (pool_pixel_valid) px.push_back(pool_pixel_in);
                if (px.size() == NPIX) begin
                    for (int k = 0; k < NOUT; k++) begin
                        base = 2 * (k / (IMG_W / 2)) * IMG_W + 2 * (k % (IMG_W / 2));
                        m = px[base];
                        for (int dy = 0; dy < 2; dy++)
                            for (int dx = 0; dx < 2; dx++) begin
                                v = px[base + dy * IMG_W + dx];
                                if (v > m) m = v;
                            end
                        rq.push_back(m);
                    end
                    for (int e = 0; e < extra; e++) rq.push_back(DATA_W'($urandom));
                    px.delete();
                    emitting = 1'b1;
                    delay = $urandom_range(0, 2);
                end
            end
            @(posedge clk);
            #2;
            pool_result_valid = 1'b0;
            pool_done = 1'b0;
            if (rst && emitting) begin
                if (delay > 0) delay--;
                else if (rq.size() > 0) begin
                    if (!(res_gaps && $urandom_range(0, 1) == 0)) begin
                        pool_result_valid = 1'b1;
                        pool_result_in = rq.pop_front();
                    end
                end else begin
                    pool_done = !nodone;
                    emitting = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT writes or completes
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (pool_start) begin
                    starts++;
                    check("no_pixel_on_start", {pool_pixel_valid, src_rd_req}, 0);
                end
                if (pool_pixel_valid) begin
                    pix++;
                    last_pix_cyc = cyc;
                    if (first_pix_cyc < 0) first_pix_cyc = cyc;
                end
                if (dst_wr_en) begin
                    if (exp_addr.size() == 0) check("unexpected_write", dst_wr_en, 0);
                    else begin
                        check("wr_addr", dst_wr_addr, exp_addr.pop_front());
                        check("wr_data", dst_wr_data, exp_data.pop_front());
                    end
                end
                if (cmd_done) begin
                    dones++;
                    done_cyc = cyc;
                    if (exp_err.size() == 0) check("unexpected_done", cmd_done, 0);
                    else check("cmd_err_at_done", cmd_err, exp_err.pop_front());
                end
            end
        end
    end

    task automatic issue(input int n, input bit err);
        @(negedge clk);
        #1;
        start_cyc = cyc;
        first_pix_cyc = -1;
        cmd_start = 1'b1;
        cmd_num_ch = 4'(n);
        if (n >= 1 && n <= MAX_CH)
            for (int c = 0; c < n; c++)
                for (int k = 0; k < NOUT; k++) begin
                    exp_addr.push_back(c * NOUT + k);
                    exp_data.push_back(ref_max(c, k));
                end
        exp_err.push_back(err);
        @(negedge clk);
        #1;
        cmd_start = 1'b0;
        check("busy_after_accept", cmd_busy, 1);
        check("err_cleared_on_accept", cmd_err, 0);
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", dones > d0, 1);
        @(negedge clk);
        check("all_writes_seen", exp_addr.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {cmd_busy, cmd_done, cmd_err, src_rd_req, pool_start, pool_pixel_valid, dst_wr_en}, 0);
        check({tag, "_src_addr"}, src_rd_addr, 0);
        check({tag, "_pixel_in"}, pool_pixel_in, 0);
        check({tag, "_dst"}, {dst_wr_addr, dst_wr_data}, 0);
    endtask

    initial begin
        int s0, p0, n;
        rst = 1'b0;
        cmd_start = 1'b0;
        cmd_num_ch = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b1;

        // ramp data, solid grant, single channel
        for (int i = 0; i < MAX_CH * NPIX; i++) mem[i] = DATA_W'(i);
        s0 = starts; p0 = pix;
        issue(1, 1'b0);
        wait_done(5000);
        check("t1_starts", starts - s0, 1);
        check("t1_pixels", pix - p0, NPIX);
        check("t1_first_pixel_latency", first_pix_cyc - start_cyc, 3);

        // random signed data, 50% grant, gappy results, three channels
        for (int i = 0; i < MAX_CH * NPIX; i++) mem[i] = DATA_W'($urandom);
        full_gnt = 1'b0; res_gaps = 1'b1;
        s0 = starts; p0 = pix;
        issue(3, 1'b0);
        wait_done(20000);
        check("t2_starts", starts - s0, 3);
        check("t2_pixels", pix - p0, 3 * NPIX);
        full_gnt = 1'b1; res_gaps = 1'b0;

        // surplus result strobe per channel is discarded
        extra = 1;
        issue(2, 1'b0);
        wait_done(8000);
        extra = 0;

        // engine never finishes: watchdog error, then a clean command clears it
        nodone = 1'b1;
        issue(1, 1'b1);
        wait_done(5000);
        check("t4_timeout_cycles", done_cyc - last_pix_cyc, TIMEOUT + 2);
        check("t4_err_sticky", cmd_err, 1);
        nodone = 1'b0;
        issue(1, 1'b0);
        wait_done(5000);

        // zero and oversized channel counts
        s0 = starts;
        issue(0, 1'b0);
        wait_done(20);
        check("t5_zero_done_latency", done_cyc - start_cyc, 2);
        issue(9, 1'b1);
        wait_done(20);
        check("t5_err_oversize", cmd_err, 1);
        check("t5_no_starts", starts - s0, 0);

        // asynchronous reset mid-feed, then a fresh command with a stray start while busy
        p0 = pix;
        issue(1, 1'b0);
        n = 0;
        while (pix - p0 < 400 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_pixel_400", pix - p0 >= 400, 1);
        #1 rst = 1'b0;
        #1 check_zero("midfeed_reset");
        exp_addr.delete(); exp_data.delete(); exp_err.delete();
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        s0 = starts;
        issue(1, 1'b0);
        repeat (50) @(negedge clk);
        #1 cmd_start = 1'b1; cmd_num_ch = 4'd2;
        @(negedge clk);
        #1 cmd_start = 1'b0;
        wait_done(5000);
        check("t6_starts_ignoring_busy_start", starts - s0, 1);
        repeat (5) @(negedge clk);
        check("t6_idle_after", cmd_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
